// File: rtl/bk_add_stager_if.sv
// Operand-in and result-out valid/ready bundle for bk_add_stager.
// The slave modport is the stage itself; master is its upstream/downstream environment.
interface bk_add_stager_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/bk_add_stager.sv
// Operand register + result FIFO around the combinational Brent-Kung adder.
// Optional BK_STAGE_CNT_EN adds a 16-bit output-handshake counter port txn_cnt.
module bk_add_stager #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bk_add_stager_if.slave   bus,
  output logic [2*W-1:0]   add_inputs,
  input  logic [W:0]       add_sum
`ifdef BK_STAGE_CNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic         opnd_v;
  logic [W-1:0] opnd_a;
  logic [W-1:0] opnd_b;
  logic [W:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic pop;
  logic can_push;
  logic push;

  assign pop          = bus.out_valid & bus.out_ready;
  assign can_push     = (count < CW'(DEPTH)) | pop;
  assign push         = opnd_v & can_push;
  assign bus.in_ready = rst_n & (~opnd_v | can_push);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_sum   = mem[rd_ptr];

  // Adder expects A/B bits interleaved: even positions A, odd positions B.
  always_comb begin
    add_inputs = '0;
    for (int unsigned i = 0; i < W; i++) begin
      add_inputs[2*i]   = opnd_a[i];
      add_inputs[2*i+1] = opnd_b[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_v <= 1'b0;
      opnd_a <= '0;
      opnd_b <= '0;
    end else begin
      if (accept) begin
        opnd_v <= 1'b1;
        opnd_a <= bus.in_a;
        opnd_b <= bus.in_b;
      end else if (push) begin
        opnd_v <= 1'b0;
      end
    end
  end

  // Storage is cleared on reset so out_sum reads zero while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= add_sum;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BK_STAGE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_cnt <= '0;
    else if (pop) txn_cnt <= txn_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bk_add_stager.sv
// Directed bench for bk_add_stager with an adder model and a result scoreboard.
// Define BK_STAGE_CNT_EN to also exercise the txn_cnt wrap.
module tb_bk_add_stager;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2*W-1:0] add_inputs;
  logic [W:0]     add_sum;
`ifdef BK_STAGE_CNT_EN
  logic [15:0]    txn_cnt;
`endif

  bk_add_stager_if #(.W(W)) bus ();

  bk_add_stager #(.W(W), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .add_inputs (add_inputs),
    .add_sum    (add_sum)
`ifdef BK_STAGE_CNT_EN
    ,
    .txn_cnt    (txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the Brent-Kung adder.
  always_comb begin
    logic [W-1:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < W; i++) begin
      a[i] = add_inputs[2*i];
      b[i] = add_inputs[2*i+1];
    end
    add_sum = {1'b0, a} + {1'b0, b};
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned n_acc  = 0;
  int unsigned n_pop  = 0;
  logic [15:0] hs_model = '0;
  logic [W:0]  sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: sample handshakes on the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [W:0] exp;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back({1'b0, bus.in_a} + {1'b0, bus.in_b});
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_pop++;
      hs_model = hs_model + 16'd1;
      if (sb.size() == 0) begin
        check("pop_on_empty_scoreboard", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("out_sum_order", 32'(bus.out_sum), 32'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    hs_model = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready",   32'(bus.in_ready),  32'd0);
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_out_sum",    32'(bus.out_sum),   32'd0);
    check("rst_add_inputs", 32'(add_inputs),    32'd0);
    do_reset();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single op with 2-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 12'h800; bus.in_b = 12'h800;
    tick();
    bus.in_valid = 1'b0;
    check("single_add_inputs", 32'(add_inputs), 32'h00C0_0000);
    check("single_valid_n1",   32'(bus.out_valid), 32'd0);
    tick();
    check("single_valid_n2", 32'(bus.out_valid), 32'd1);
    check("single_sum",      32'(bus.out_sum),   32'h1000);
    tick();
    check("single_drained", 32'(bus.out_valid), 32'd0);

    // Streaming 16 random pairs at full rate
    n_pop = 0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("stream_pops_in_18_cycles", 32'(n_pop), 32'd16);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: DEPTH results plus one operand pair
    bus.out_ready = 1'b0;
    n_acc = 0;
    n_pop = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepts",   32'(n_acc), 32'd5);
    check("bp_in_ready",  32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_count_full", 32'(dut.count), 32'd4);

    // Full with operand held: one-cycle release gives simultaneous push and pop
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_on_pop", 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    check("pushpop_count", 32'(dut.count), 32'd4);
    check("pushpop_opnd_free", 32'(bus.in_ready), 32'd1);
    check("pushpop_one_pop", 32'(n_pop), 32'd1);
    tick();
    check("pushpop_count_hold", 32'(dut.count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_total_pops", 32'(n_pop), 32'd5);
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset with three results buffered
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("mid_buffered", 32'(dut.count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum",    32'(bus.out_sum),   32'd0);
    check("mid_rst_add_inputs", 32'(add_inputs),    32'd0);
    check("mid_rst_in_ready",   32'(bus.in_ready),  32'd0);
    sb.delete();
    hs_model = '0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n_pop = 0;
    tick();
    tick();
    check("mid_no_handshake", 32'(n_pop), 32'd0);
    bus.in_valid = 1'b1; bus.in_a = 12'hFFF; bus.in_b = 12'h001;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_new_valid", 32'(bus.out_valid), 32'd1);
    check("mid_new_sum",   32'(bus.out_sum),   32'h1000);
    tick();
    check("mid_new_popped", 32'(n_pop), 32'd1);

`ifdef BK_STAGE_CNT_EN
    check("cnt_track", 32'(txn_cnt), 32'(hs_model));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 70000 && hs_model != 16'hFFFF; i++) begin
      bus.in_a = W'(i);
      bus.in_b = W'(i >> 3);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("cnt_ffff", 32'(txn_cnt), 32'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("cnt_wrap0", 32'(txn_cnt), 32'h0000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("cnt_wrap1", 32'(txn_cnt), 32'h0001);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
